// File: rtl/dmem_pkg.sv
// Shared types, constants and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int LANE_BITS = 2;
  localparam int WORD_BITS = 32;

  // A word access must sit on a 4-byte boundary; byte accesses may use any lane.
  function automatic logic dmem_misaligned(input logic [31:0] addr, input logic byte_acc);
    return (!byte_acc) && (addr[LANE_BITS-1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges a byte store into the old word and
// extracts a sign-extended byte for loads (little-endian lanes).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [LANE_BITS-1:0] lane,
  input  logic                 byte_acc,
  input  logic [WORD_BITS-1:0] old_word,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] store_word,
  output logic [WORD_BITS-1:0] load_word
);

  logic [7:0] lane_byte_s;

  // Select store merge and load extraction for the addressed lane.
  always_comb begin
    store_word  = old_word;
    load_word   = old_word;
    lane_byte_s = old_word[7:0];
    if (byte_acc) begin
      case (lane)
        2'd0: begin
          store_word[7:0] = wdata[7:0];
          lane_byte_s     = old_word[7:0];
        end
        2'd1: begin
          store_word[15:8] = wdata[7:0];
          lane_byte_s      = old_word[15:8];
        end
        2'd2: begin
          store_word[23:16] = wdata[7:0];
          lane_byte_s       = old_word[23:16];
        end
        2'd3: begin
          store_word[31:24] = wdata[7:0];
          lane_byte_s       = old_word[31:24];
        end
        default: begin
          store_word  = old_word;
          lane_byte_s = 8'h00;
        end
      endcase
      load_word = {{24{lane_byte_s[7]}}, lane_byte_s};
    end else begin
      store_word = wdata;
      load_word  = old_word;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, LATENCY wait states,
// one-cycle response pulse and a pipeline stall line.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_stall
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int CNT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam bit ZERO_LAT  = (LATENCY == 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  dmem_state_t          state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 write_r;
  logic                 byte_r;
  logic [31:0]          addr_r;
  logic [31:0]          wdata_r;
  logic                 rsp_valid_r;
  logic                 rsp_err_r;
  logic [31:0]          rsp_rdata_r;
  logic [31:0]          mem_r [DEPTH_WORDS];

  logic                 acc_write_s;
  logic                 acc_byte_s;
  logic [31:0]          acc_addr_s;
  logic [31:0]          acc_wdata_s;
  logic                 enter_resp_s;
  logic                 err_s;
  logic                 commit_s;
  logic [IDX_W-1:0]     idx_s;
  logic [31:0]          old_word_s;
  logic [31:0]          store_word_s;
  logic [31:0]          load_word_s;

  // With zero wait states the access completes on the accepting edge, so use
  // the live request; otherwise use the fields latched at acceptance.
  always_comb begin
    acc_write_s = write_r;
    acc_byte_s  = byte_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      acc_write_s = req_write;
      acc_byte_s  = req_byte;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_write_s = write_r;
      acc_byte_s  = byte_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  assign enter_resp_s = ((state_r == IDLE) && req_valid && ZERO_LAT) ||
                        ((state_r == BUSY) && (cnt_r == CNT_LAST));
  assign err_s        = dmem_misaligned(acc_addr_s, acc_byte_s) ||
                        ({2'b00, acc_addr_s[31:2]} >= 32'(DEPTH_WORDS));
  assign idx_s        = acc_addr_s[IDX_W+1:2];
  assign old_word_s   = mem_r[idx_s];
  assign commit_s     = enter_resp_s && acc_write_s && !err_s && !reset;

  dmem_lane_align u_lane_align (
    .lane       (acc_addr_s[LANE_BITS-1:0]),
    .byte_acc   (acc_byte_s),
    .old_word   (old_word_s),
    .wdata      (acc_wdata_s),
    .store_word (store_word_s),
    .load_word  (load_word_s)
  );

  // Control FSM, wait counter, request latches and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      write_r     <= 1'b0;
      byte_r      <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      rsp_valid_r <= enter_resp_s;
      rsp_err_r   <= enter_resp_s && err_s;
      if (enter_resp_s) begin
        rsp_rdata_r <= (err_s || acc_write_s) ? 32'h0000_0000 : load_word_s;
      end
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r <= req_write;
            byte_r  <= req_byte;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            cnt_r   <= '0;
            state_r <= ZERO_LAT ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Array write port; the array is never reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[idx_s] <= store_word_s;
    end
  end

  assign req_ready = (state_r == IDLE);
  assign mem_stall = ((state_r == IDLE) && req_valid) || (state_r == BUSY);
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: dut_a uses LATENCY=2, dut_b uses LATENCY=0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_valid, a_write, a_byte;
  logic [31:0] a_addr, a_wdata;
  logic        a_ready, a_rsp_valid, a_rsp_err, a_stall;
  logic [31:0] a_rdata;

  logic        b_valid, b_write, b_byte;
  logic [31:0] b_addr, b_wdata;
  logic        b_ready, b_rsp_valid, b_rsp_err, b_stall;
  logic [31:0] b_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_write(a_write), .req_byte(a_byte),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
    .rsp_err(a_rsp_err), .mem_stall(a_stall)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_write(b_write), .req_byte(b_byte),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
    .rsp_err(b_rsp_err), .mem_stall(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h, required %h", tag, obs, exp);
  endtask

  // One access on dut_a, starting just after a rising edge in IDLE.
  task automatic acc_a(input string tag, input logic w, input logic b,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    lat = -1;
    a_valid = 1'b1; a_write = w; a_byte = b; a_addr = addr; a_wdata = wd;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(a_ready), 32'd1);
    chk({tag, "_stall_idle"}, 32'(a_stall), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (a_rsp_valid === 1'b1) lat = k;
      else chk({tag, "_stall_wait"}, 32'(a_stall), 32'd1);
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_err"}, 32'(a_rsp_err), 32'(exp_err));
    chk({tag, "_rdata"}, a_rdata, exp_rd);
    chk({tag, "_stall_resp"}, 32'(a_stall), 32'd0);
    a_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(a_rsp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_byte = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_valid = 1'b0; b_write = 1'b0; b_byte = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_err", 32'(a_rsp_err), 32'd0);
    chk("rst_stall", 32'(a_stall), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    @(posedge clk); #1;

    // Word round trip
    acc_a("sw40", 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0);
    acc_a("lw40", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Byte lanes
    acc_a("sw80", 1'b1, 1'b0, 32'h80, 32'h1122_3344, 1'b0, 32'h0);
    acc_a("sb82", 1'b1, 1'b1, 32'h82, 32'h1234_56A5, 1'b0, 32'h0);
    acc_a("lw80", 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h11A5_3344);
    acc_a("lb82", 1'b0, 1'b1, 32'h82, 32'h0, 1'b0, 32'hFFFF_FFA5);
    acc_a("lb80", 1'b0, 1'b1, 32'h80, 32'h0, 1'b0, 32'h0000_0044);
    acc_a("sb3ff", 1'b1, 1'b1, 32'h3FF, 32'h0000_007F, 1'b0, 32'h0);
    acc_a("lb3ff", 1'b0, 1'b1, 32'h3FF, 32'h0, 1'b0, 32'h0000_007F);

    // Errors
    acc_a("sw41", 1'b1, 1'b0, 32'h41, 32'h5555_5555, 1'b1, 32'h0);
    acc_a("lw40b", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF);
    acc_a("lw400", 1'b0, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);

    // Reset during BUSY drops the pending store
    acc_a("sw10", 1'b1, 1'b0, 32'h10, 32'hAAAA_5555, 1'b0, 32'h0);
    a_valid = 1'b1; a_write = 1'b1; a_byte = 1'b0; a_addr = 32'h10; a_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("abort_busy_ready", 32'(a_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(a_rsp_valid), 32'd0);
    end
    chk("abort_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    acc_a("lw10", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hAAAA_5555);

    // Zero-latency: stores then loads with req_valid held continuously
    for (int pass = 0; pass < 2; pass++) begin
      b_valid = 1'b1; b_write = (pass == 0); b_byte = 1'b0;
      b_addr = 32'h0; b_wdata = 32'hCAFE_0000;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("b_idle_ready", 32'(b_ready), 32'd1);
        chk("b_idle_no_rsp", 32'(b_rsp_valid), 32'd0);
        chk("b_idle_stall", 32'(b_stall), 32'd1);
        @(negedge clk);
        chk("b_resp_valid", 32'(b_rsp_valid), 32'd1);
        chk("b_resp_ready", 32'(b_ready), 32'd0);
        chk("b_resp_stall", 32'(b_stall), 32'd0);
        chk("b_resp_err", 32'(b_rsp_err), 32'd0);
        chk("b_resp_rdata", b_rdata, (pass == 0) ? 32'h0 : (32'hCAFE_0000 | 32'(i)));
        b_addr  = 32'(4 * (i + 1));
        b_wdata = 32'hCAFE_0000 | 32'(i + 1);
      end
      b_valid = 1'b0;
      @(negedge clk);
      chk("b_tail_no_rsp", 32'(b_rsp_valid), 32'd0);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
